// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, ALU opcodes and the ID/EX register layout for the EX front end.
// The decoder, the ALU and this stage all take these definitions from here.
package id_ex_operand_stage_pkg;

  localparam int XLEN      = 32;
  localparam int RADDR_W   = 5;
  localparam int ALUCODE_W = 4;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [RADDR_W-1:0]   raddr_t;
  typedef logic [ALUCODE_W-1:0] alu_code_t;

  localparam alu_code_t alu_add  = 4'd0;
  localparam alu_code_t alu_sub  = 4'd1;
  localparam alu_code_t alu_sll  = 4'd2;
  localparam alu_code_t alu_slt  = 4'd3;
  localparam alu_code_t alu_sltu = 4'd4;
  localparam alu_code_t alu_xor  = 4'd5;
  localparam alu_code_t alu_srl  = 4'd6;
  localparam alu_code_t alu_sra  = 4'd7;
  localparam alu_code_t alu_or   = 4'd8;
  localparam alu_code_t alu_and  = 4'd9;

  typedef struct packed {
    word_t     pc;
    word_t     rs1_data;
    word_t     rs2_data;
    word_t     imm;
    raddr_t    rs1_addr;
    raddr_t    rs2_addr;
    raddr_t    rd_addr;
    alu_code_t alu_code;
    logic      alu_src_a;
    logic      alu_src_b;
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      mem_to_reg;
  } id_ex_t;

  // All-zero word: an add that writes no register and touches no memory.
  localparam id_ex_t BUBBLE = '0;

  // True when a writer targets the given source register; x0 never matches.
  function automatic logic reg_hit(input logic we, input raddr_t rd, input raddr_t rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side, MEM/WB-feedback and EX-side signals around the ID/EX stage.
// slave is the stage itself; master is whatever drives ID and consumes EX.
interface id_ex_operand_stage_if;
  import id_ex_operand_stage_pkg::*;

  logic      Flush;
  word_t     ID_PC, ID_rs1Data, ID_rs2Data, ID_Imm;
  raddr_t    ID_rs1Addr, ID_rs2Addr, ID_rdAddr;
  alu_code_t ID_ALUCode;
  logic      ID_ALUSrcA, ID_ALUSrcB;
  logic      ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg;

  logic      MEM_RegWrite;
  raddr_t    MEM_rdAddr;
  word_t     MEM_ALUResult;
  logic      WB_RegWrite;
  raddr_t    WB_rdAddr;
  word_t     WB_Data;

  logic      Stall;
  alu_code_t EX_ALUCode;
  word_t     EX_A, EX_B, EX_StoreData;
  raddr_t    EX_rdAddr;
  logic      EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg;

  modport slave (
    input  Flush, ID_PC, ID_rs1Data, ID_rs2Data, ID_Imm,
           ID_rs1Addr, ID_rs2Addr, ID_rdAddr, ID_ALUCode, ID_ALUSrcA, ID_ALUSrcB,
           ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg,
           MEM_RegWrite, MEM_rdAddr, MEM_ALUResult, WB_RegWrite, WB_rdAddr, WB_Data,
    output Stall, EX_ALUCode, EX_A, EX_B, EX_StoreData, EX_rdAddr,
           EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg
  );

  modport master (
    output Flush, ID_PC, ID_rs1Data, ID_rs2Data, ID_Imm,
           ID_rs1Addr, ID_rs2Addr, ID_rdAddr, ID_ALUCode, ID_ALUSrcA, ID_ALUSrcB,
           ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg,
           MEM_RegWrite, MEM_rdAddr, MEM_ALUResult, WB_RegWrite, WB_rdAddr, WB_Data,
    input  Stall, EX_ALUCode, EX_A, EX_B, EX_StoreData, EX_rdAddr,
           EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_unit.sv
// Combinational RAW bypass for one EX source operand.
// MEM is the younger producer, so it wins over WB.
module fwd_unit
  import id_ex_operand_stage_pkg::*;
(
  input  raddr_t rs_addr,
  input  word_t  rs_data,
  input  logic   mem_reg_write,
  input  raddr_t mem_rd_addr,
  input  word_t  mem_result,
  input  logic   wb_reg_write,
  input  raddr_t wb_rd_addr,
  input  word_t  wb_data,
  output word_t  fwd_data
);

  always_comb begin
    // NOTE: default assignment first so every path drives fwd_data and no latch is inferred.
    fwd_data = rs_data;
    if (reg_hit(mem_reg_write, mem_rd_addr, rs_addr)) begin
      fwd_data = mem_result;
    end else if (reg_hit(wb_reg_write, wb_rd_addr, rs_addr)) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB write-through on
// capture, and MEM/WB forwarding into the ALU operand and store-data outputs.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  id_ex_operand_stage_if.slave  bus
);

  id_ex_t ex_q;
  id_ex_t id_d;
  word_t  fwd_rs1;
  word_t  fwd_rs2;
  logic   stall;

  // The register file writes on the same edge we capture, so take WB's value directly.
  always_comb begin
    id_d            = BUBBLE;
    id_d.pc         = bus.ID_PC;
    id_d.rs1_data   = reg_hit(bus.WB_RegWrite, bus.WB_rdAddr, bus.ID_rs1Addr)
                      ? bus.WB_Data : bus.ID_rs1Data;
    id_d.rs2_data   = reg_hit(bus.WB_RegWrite, bus.WB_rdAddr, bus.ID_rs2Addr)
                      ? bus.WB_Data : bus.ID_rs2Data;
    id_d.imm        = bus.ID_Imm;
    id_d.rs1_addr   = bus.ID_rs1Addr;
    id_d.rs2_addr   = bus.ID_rs2Addr;
    id_d.rd_addr    = bus.ID_rdAddr;
    id_d.alu_code   = bus.ID_ALUCode;
    id_d.alu_src_a  = bus.ID_ALUSrcA;
    id_d.alu_src_b  = bus.ID_ALUSrcB;
    id_d.mem_read   = bus.ID_MemRead;
    id_d.mem_write  = bus.ID_MemWrite;
    id_d.reg_write  = bus.ID_RegWrite;
    id_d.mem_to_reg = bus.ID_MemtoReg;
  end

  // A load in EX whose result the ID instruction needs cannot be bypassed in time.
  assign stall = ex_q.mem_read && (ex_q.rd_addr != '0) &&
                 ((ex_q.rd_addr == bus.ID_rs1Addr) || (ex_q.rd_addr == bus.ID_rs2Addr));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= BUBBLE;
    end else if (bus.Flush || stall) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= id_d;
    end
  end

  fwd_unit u_fwd_rs1 (
    .rs_addr       (ex_q.rs1_addr),
    .rs_data       (ex_q.rs1_data),
    .mem_reg_write (bus.MEM_RegWrite),
    .mem_rd_addr   (bus.MEM_rdAddr),
    .mem_result    (bus.MEM_ALUResult),
    .wb_reg_write  (bus.WB_RegWrite),
    .wb_rd_addr    (bus.WB_rdAddr),
    .wb_data       (bus.WB_Data),
    .fwd_data      (fwd_rs1)
  );

  fwd_unit u_fwd_rs2 (
    .rs_addr       (ex_q.rs2_addr),
    .rs_data       (ex_q.rs2_data),
    .mem_reg_write (bus.MEM_RegWrite),
    .mem_rd_addr   (bus.MEM_rdAddr),
    .mem_result    (bus.MEM_ALUResult),
    .wb_reg_write  (bus.WB_RegWrite),
    .wb_rd_addr    (bus.WB_rdAddr),
    .wb_data       (bus.WB_Data),
    .fwd_data      (fwd_rs2)
  );

  assign bus.Stall        = stall;
  assign bus.EX_ALUCode   = ex_q.alu_code;
  assign bus.EX_A         = ex_q.alu_src_a ? ex_q.pc  : fwd_rs1;
  assign bus.EX_B         = ex_q.alu_src_b ? ex_q.imm : fwd_rs2;
  assign bus.EX_StoreData = fwd_rs2;
  assign bus.EX_rdAddr    = ex_q.rd_addr;
  assign bus.EX_MemRead   = ex_q.mem_read;
  assign bus.EX_MemWrite  = ex_q.mem_write;
  assign bus.EX_RegWrite  = ex_q.reg_write;
  assign bus.EX_MemtoReg  = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a vector table for capture and
// forwarding, plus hand sequences for load-use, flush and reset corners.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    word_t     pc, rs1_data, rs2_data, imm;
    raddr_t    rs1, rs2, rd;
    alu_code_t alu;
    logic      src_a, src_b;
    logic [3:0] ctrl;           // {MemRead, MemWrite, RegWrite, MemtoReg}
    logic      flush;
    logic      cap_wb_we;
    raddr_t    cap_wb_rd;
    word_t     cap_wb_data;
    logic      mem_we;
    raddr_t    mem_rd;
    word_t     mem_data;
    logic      wb_we;
    raddr_t    wb_rd;
    word_t     wb_data;
    logic      exp_stall;
    word_t     exp_a, exp_b, exp_store;
    raddr_t    exp_rd;
    alu_code_t exp_alu;
    logic [3:0] exp_ctrl;
  } vec_t;

  localparam int NVEC = 5;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Flush = 0;
    bus.ID_PC = '0; bus.ID_rs1Data = '0; bus.ID_rs2Data = '0; bus.ID_Imm = '0;
    bus.ID_rs1Addr = '0; bus.ID_rs2Addr = '0; bus.ID_rdAddr = '0;
    bus.ID_ALUCode = alu_add; bus.ID_ALUSrcA = 0; bus.ID_ALUSrcB = 0;
    bus.ID_MemRead = 0; bus.ID_MemWrite = 0; bus.ID_RegWrite = 0; bus.ID_MemtoReg = 0;
    bus.MEM_RegWrite = 0; bus.MEM_rdAddr = '0; bus.MEM_ALUResult = '0;
    bus.WB_RegWrite = 0; bus.WB_rdAddr = '0; bus.WB_Data = '0;
  endtask

  task automatic drive_id(input word_t pc, input word_t d1, input word_t d2, input word_t imm,
                          input raddr_t rs1, input raddr_t rs2, input raddr_t rd,
                          input alu_code_t alu, input logic sa, input logic sb,
                          input logic [3:0] ctrl);
    bus.ID_PC = pc; bus.ID_rs1Data = d1; bus.ID_rs2Data = d2; bus.ID_Imm = imm;
    bus.ID_rs1Addr = rs1; bus.ID_rs2Addr = rs2; bus.ID_rdAddr = rd;
    bus.ID_ALUCode = alu; bus.ID_ALUSrcA = sa; bus.ID_ALUSrcB = sb;
    {bus.ID_MemRead, bus.ID_MemWrite, bus.ID_RegWrite, bus.ID_MemtoReg} = ctrl;
  endtask

  function automatic logic [3:0] ex_ctrl();
    return {bus.EX_MemRead, bus.EX_MemWrite, bus.EX_RegWrite, bus.EX_MemtoReg};
  endfunction

  task automatic fill_vectors();
    vec_t v;
    // 0: MEM and WB both target rs1=x5; MEM wins.
    v = '0;
    v.pc = 32'h100; v.rs1 = 5; v.rs1_data = 32'h10; v.rs2 = 6; v.rs2_data = 32'h20;
    v.rd = 8; v.alu = alu_add; v.ctrl = 4'b0010;
    v.mem_we = 1; v.mem_rd = 5; v.mem_data = 32'h1234;
    v.wb_we = 1; v.wb_rd = 5; v.wb_data = 32'hBEEF;
    v.exp_a = 32'h1234; v.exp_b = 32'h20; v.exp_store = 32'h20;
    v.exp_rd = 8; v.exp_alu = alu_add; v.exp_ctrl = 4'b0010;
    vecs[0] = v;
    // 1: PC/Imm select; store data still forwarded from MEM on rs2.
    v = '0;
    v.pc = 32'h400; v.imm = 32'hFFFFF000; v.rs1 = 1; v.rs1_data = 32'h7; v.rs2 = 2; v.rs2_data = 32'h9;
    v.rd = 9; v.alu = alu_sub; v.src_a = 1; v.src_b = 1; v.ctrl = 4'b0010;
    v.mem_we = 1; v.mem_rd = 2; v.mem_data = 32'h333;
    v.exp_a = 32'h400; v.exp_b = 32'hFFFFF000; v.exp_store = 32'h333;
    v.exp_rd = 9; v.exp_alu = alu_sub; v.exp_ctrl = 4'b0010;
    vecs[1] = v;
    // 2: WB writes x3 on the capture edge; stale 0x11 replaced by 0x55.
    v = '0;
    v.rs1 = 3; v.rs1_data = 32'h11; v.rs2 = 4; v.rs2_data = 32'h44;
    v.rd = 10; v.alu = alu_and; v.ctrl = 4'b0010;
    v.cap_wb_we = 1; v.cap_wb_rd = 3; v.cap_wb_data = 32'h55;
    v.wb_we = 1; v.wb_rd = 12; v.wb_data = 32'hDEAD;
    v.exp_a = 32'h55; v.exp_b = 32'h44; v.exp_store = 32'h44;
    v.exp_rd = 10; v.exp_alu = alu_and; v.exp_ctrl = 4'b0010;
    vecs[2] = v;
    // 3: x0 is never written through nor forwarded.
    v = '0;
    v.rd = 11; v.alu = alu_or; v.ctrl = 4'b0011;
    v.cap_wb_we = 1; v.cap_wb_rd = 0; v.cap_wb_data = 32'h77;
    v.mem_we = 1; v.mem_rd = 0; v.mem_data = 32'h999;
    v.wb_we = 1; v.wb_rd = 0; v.wb_data = 32'h888;
    v.exp_a = 32'h0; v.exp_b = 32'h0; v.exp_store = 32'h0;
    v.exp_rd = 11; v.exp_alu = alu_or; v.exp_ctrl = 4'b0011;
    vecs[3] = v;
    // 4: write-through on rs2, WB forward on rs1, MEM ignored while RegWrite=0.
    v = '0;
    v.rs1 = 13; v.rs1_data = 32'h13; v.rs2 = 14; v.rs2_data = 32'h14;
    v.rd = 15; v.alu = alu_xor; v.ctrl = 4'b0100;
    v.cap_wb_we = 1; v.cap_wb_rd = 14; v.cap_wb_data = 32'h1400;
    v.mem_we = 0; v.mem_rd = 13; v.mem_data = 32'hBAD;
    v.wb_we = 1; v.wb_rd = 13; v.wb_data = 32'hAAAA;
    v.exp_a = 32'hAAAA; v.exp_b = 32'h1400; v.exp_store = 32'h1400;
    v.exp_rd = 15; v.exp_alu = alu_xor; v.exp_ctrl = 4'b0100;
    vecs[4] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    fill_vectors();

    // Reset with live ID fields: everything must come out zero.
    reset = 1;
    drive_id(32'h80, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, alu_sub, 1, 1, 4'b1111);
    tick();
    tick();
    check("reset_alu", 32'(bus.EX_ALUCode), 32'h0);
    check("reset_a", bus.EX_A, 32'h0);
    check("reset_b", bus.EX_B, 32'h0);
    check("reset_store", bus.EX_StoreData, 32'h0);
    check("reset_rd", 32'(bus.EX_rdAddr), 32'h0);
    check("reset_ctrl", 32'(ex_ctrl()), 32'h0);
    check("reset_stall", 32'(bus.Stall), 32'h0);
    reset = 0;
    clear_inputs();

    // Table: capture, then apply MEM/WB feedback and check the EX outputs.
    for (int i = 0; i < NVEC; i++) begin
      drive_id(vecs[i].pc, vecs[i].rs1_data, vecs[i].rs2_data, vecs[i].imm,
               vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].alu,
               vecs[i].src_a, vecs[i].src_b, vecs[i].ctrl);
      bus.Flush = vecs[i].flush;
      bus.MEM_RegWrite = 0;
      bus.WB_RegWrite = vecs[i].cap_wb_we; bus.WB_rdAddr = vecs[i].cap_wb_rd;
      bus.WB_Data = vecs[i].cap_wb_data;
      #1;
      check($sformatf("v%0d_stall", i), 32'(bus.Stall), 32'(vecs[i].exp_stall));
      tick();
      clear_inputs();
      bus.MEM_RegWrite = vecs[i].mem_we; bus.MEM_rdAddr = vecs[i].mem_rd;
      bus.MEM_ALUResult = vecs[i].mem_data;
      bus.WB_RegWrite = vecs[i].wb_we; bus.WB_rdAddr = vecs[i].wb_rd;
      bus.WB_Data = vecs[i].wb_data;
      #1;
      check($sformatf("v%0d_a", i), bus.EX_A, vecs[i].exp_a);
      check($sformatf("v%0d_b", i), bus.EX_B, vecs[i].exp_b);
      check($sformatf("v%0d_store", i), bus.EX_StoreData, vecs[i].exp_store);
      check($sformatf("v%0d_rd", i), 32'(bus.EX_rdAddr), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_alu", i), 32'(bus.EX_ALUCode), 32'(vecs[i].exp_alu));
      check($sformatf("v%0d_ctrl", i), 32'(ex_ctrl()), 32'(vecs[i].exp_ctrl));
    end

    // Load-use: lw x7 in EX, consumer reads x7 as rs2.
    clear_inputs();
    drive_id(32'h200, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd0, 5'd7, alu_add, 0, 1, 4'b1011);
    tick();
    drive_id(32'h204, 32'h5, 32'h0, 32'h0, 5'd1, 5'd7, 5'd8, alu_add, 0, 0, 4'b0010);
    #1;
    check("lu_stall", 32'(bus.Stall), 32'h1);
    tick();
    check("lu_bubble_regwrite", 32'(bus.EX_RegWrite), 32'h0);
    check("lu_bubble_memread", 32'(bus.EX_MemRead), 32'h0);
    check("lu_no_second_stall", 32'(bus.Stall), 32'h0);
    tick();
    clear_inputs();
    bus.WB_RegWrite = 1; bus.WB_rdAddr = 5'd7; bus.WB_Data = 32'hCAFE;
    #1;
    check("lu_consumer_b", bus.EX_B, 32'hCAFE);
    check("lu_consumer_rd", 32'(bus.EX_rdAddr), 32'd8);
    check("lu_consumer_regwrite", 32'(bus.EX_RegWrite), 32'h1);

    // lw to x0 never stalls even when ID reads x0.
    clear_inputs();
    drive_id(32'h300, 32'h0, 32'h0, 32'h8, 5'd2, 5'd0, 5'd0, alu_add, 0, 1, 4'b1011);
    tick();
    drive_id(32'h304, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, alu_add, 0, 0, 4'b0010);
    #1;
    check("x0_load_stall", 32'(bus.Stall), 32'h0);

    // Flush squashes a store entering EX.
    clear_inputs();
    drive_id(32'h500, 32'h2, 32'h3, 32'h10, 5'd2, 5'd3, 5'd4, alu_add, 0, 1, 4'b0110);
    bus.Flush = 1;
    tick();
    check("flush_memwrite", 32'(bus.EX_MemWrite), 32'h0);
    check("flush_regwrite", 32'(bus.EX_RegWrite), 32'h0);
    check("flush_rd", 32'(bus.EX_rdAddr), 32'h0);

    // Flush and Stall together: Stall still driven, bubble loaded.
    clear_inputs();
    drive_id(32'h600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, alu_add, 0, 1, 4'b1011);
    tick();
    drive_id(32'h604, 32'h0, 32'h0, 32'h0, 5'd7, 5'd2, 5'd6, alu_add, 0, 0, 4'b0010);
    bus.Flush = 1;
    #1;
    check("flush_stall_stall", 32'(bus.Stall), 32'h1);
    tick();
    check("flush_stall_bubble", 32'(ex_ctrl()), 32'h0);

    // Reset mid-operation clears a load in EX and drops the stall.
    clear_inputs();
    drive_id(32'h700, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, alu_add, 0, 1, 4'b1011);
    tick();
    drive_id(32'h704, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0, 5'd6, alu_add, 0, 0, 4'b0010);
    #1;
    check("midreset_pre_stall", 32'(bus.Stall), 32'h1);
    reset = 1;
    tick();
    check("midreset_stall", 32'(bus.Stall), 32'h0);
    check("midreset_memread", 32'(bus.EX_MemRead), 32'h0);
    check("midreset_rd", 32'(bus.EX_rdAddr), 32'h0);
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
